// File: rtl/lift_pkg.sv
// Shared definitions for the lift scheduler: FSM state encoding and
// one-hot floor mask helpers used by the direction decision.
package lift_pkg;

    localparam int NUM_FLOORS_DEF = 3;
    localparam int MAX_FLOORS     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR,
        S_FAULT
    } state_t;

    typedef logic [MAX_FLOORS-1:0] floor_vec_t;

    // Floors strictly above the one-hot floor f.
    function automatic floor_vec_t above_mask(input floor_vec_t f);
        return ~((f << 1) - floor_vec_t'(1));
    endfunction

    // Floors strictly below the one-hot floor f.
    function automatic floor_vec_t below_mask(input floor_vec_t f);
        return f - floor_vec_t'(1);
    endfunction

endpackage

// File: rtl/lift_door_timer.sv
// Door dwell counter: load starts (or restarts) a CYCLES-long dwell,
// done is high in the final dwell cycle and whenever no dwell is running.
module lift_door_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= W'(CYCLES - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler and motion sequencer: latches calls, chooses travel
// direction, drives motor/door from floor sensors, faults on bad sensors or stalls.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int DOOR_CYCLES  = 4,
    parameter int MOVE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [NUM_FLOORS-1:0] floor_sensor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] cur_floor,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  dir_up,
    output logic                  idle,
    output logic                  fault
);
    localparam int MCW = $clog2(MOVE_TIMEOUT);

    state_t          state;
    logic [MCW-1:0]  move_cnt;
    logic            door_done;

    logic sensor_onehot, sensor_multi, sensor_new, arrive, at_top, at_bottom;
    logic [NUM_FLOORS-1:0] calls_above, calls_below, clear, block;
    logic here, go_up, go_down, moving, timed_out;
    logic take_idle_door, take_arrive, door_restart, door_load;

    assign sensor_onehot = $onehot(floor_sensor);
    assign sensor_multi  = (floor_sensor != '0) && !sensor_onehot;
    assign sensor_new    = sensor_onehot && (floor_sensor != cur_floor);
    assign arrive        = sensor_onehot && ((pending & floor_sensor) != '0);
    assign at_top        = sensor_onehot && floor_sensor[NUM_FLOORS-1];
    assign at_bottom     = sensor_onehot && floor_sensor[0];
    assign moving        = (state == S_MOVE_UP) || (state == S_MOVE_DOWN);
    assign timed_out     = !sensor_new && (move_cnt == MCW'(MOVE_TIMEOUT - 1));

    // SCAN rule: keep going up while calls lie above, unless already heading
    // down with calls still below.
    assign calls_above = pending & NUM_FLOORS'(above_mask(MAX_FLOORS'(cur_floor)));
    assign calls_below = pending & NUM_FLOORS'(below_mask(MAX_FLOORS'(cur_floor)));
    assign here        = (pending & cur_floor) != '0;
    assign go_up       = (calls_above != '0) && (dir_up || (calls_below == '0));
    assign go_down     = !go_up && (calls_below != '0);

    assign take_idle_door = !sensor_multi && (state == S_IDLE) && here;
    assign take_arrive    = !sensor_multi && moving && arrive;
    assign door_restart   = !sensor_multi && (state == S_DOOR) && ((call_req & cur_floor) != '0);
    assign door_load      = take_idle_door || take_arrive || door_restart;

    always_comb begin
        clear = '0;
        if (take_idle_door)
            clear = cur_floor;
        else if (take_arrive)
            clear = floor_sensor;
        block = (state == S_DOOR) ? cur_floor : '0;
    end

    lift_door_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .load  (door_load),
        .done  (door_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= '0;
            cur_floor <= NUM_FLOORS'(1);
            dir_up    <= 1'b1;
            move_cnt  <= '0;
        end else begin
            // Clear beats a same-cycle call on the arrival floor.
            pending  <= (pending | (call_req & ~block)) & ~clear;
            move_cnt <= sensor_new ? '0 : move_cnt + 1'b1;
            if (sensor_onehot)
                cur_floor <= floor_sensor;

            if (sensor_multi) begin
                state <= S_FAULT;
            end else begin
                case (state)
                    S_IDLE, S_DOOR: begin
                        if (state == S_IDLE && here) begin
                            state <= S_DOOR;
                        end else if (state == S_DOOR && (door_restart || !door_done)) begin
                            state <= S_DOOR;
                        end else if (go_up) begin
                            state    <= S_MOVE_UP;
                            dir_up   <= 1'b1;
                            move_cnt <= '0;
                        end else if (go_down) begin
                            state    <= S_MOVE_DOWN;
                            dir_up   <= 1'b0;
                            move_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_MOVE_UP: begin
                        if (arrive)         state <= S_DOOR;
                        else if (at_top)    state <= S_IDLE;
                        else if (timed_out) state <= S_FAULT;
                    end
                    S_MOVE_DOWN: begin
                        if (arrive)         state <= S_DOOR;
                        else if (at_bottom) state <= S_IDLE;
                        else if (timed_out) state <= S_FAULT;
                    end
                    default: state <= S_FAULT;
                endcase
            end
        end
    end

    assign motor_up   = (state == S_MOVE_UP);
    assign motor_down = (state == S_MOVE_DOWN);
    assign door_open  = (state == S_DOOR);
    assign fault      = (state == S_FAULT);
    assign idle       = (state == S_IDLE) && (pending == '0);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: per-cycle vector table for the
// travel/door/reset scenarios plus hand sequences for fault and stall timeout.
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] call_req = 3'b000;
    logic [2:0] floor_sensor = 3'b001;
    logic [2:0] pending, cur_floor;
    logic       motor_up, motor_down, door_open, dir_up, idle, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lift_call_scheduler #(
        .NUM_FLOORS   (3),
        .DOOR_CYCLES  (4),
        .MOVE_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .floor_sensor (floor_sensor),
        .pending      (pending),
        .cur_floor    (cur_floor),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .idle         (idle),
        .fault        (fault)
    );

    typedef struct {
        logic       rst;
        logic [2:0] call;
        logic [2:0] sens;
        logic [11:0] exp; // {pending, cur_floor, mu, md, door, dir_up, idle, fault}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic [2:0] c, input logic [2:0] s,
                               input logic [2:0] p, input logic [2:0] cf,
                               input logic mu, input logic md, input logic dr,
                               input logic du, input logic id, input logic fl);
        vec_t x;
        x.rst = r; x.call = c; x.sens = s;
        x.exp = {p, cf, mu, md, dr, du, id, fl};
        return x;
    endfunction

    function automatic logic [11:0] outs();
        return {pending, cur_floor, motor_up, motor_down, door_open, dir_up, idle, fault};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] c, input logic [2:0] s);
        reset = r; call_req = c; floor_sensor = s;
        @(posedge clk);
        #1;
    endtask

    localparam logic [11:0] RST_OUT = {3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        //      rst call  sens   pend   cur    mu md dr du id fl
        // Call to floor 2 from ground, travel, door dwell, back to idle.
        vecs.push_back(v(1, 3'b000, 3'b001, 3'b000, 3'b001, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 3'b100, 3'b001, 3'b100, 3'b001, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b001, 3'b100, 3'b001, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b001, 3'b100, 3'b001, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b100, 3'b001, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b100, 3'b010, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b100, 3'b010, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 0, 1, 1, 0));
        // Call below while passing floor 1 upward: finish up, then reverse.
        vecs.push_back(v(1, 3'b000, 3'b001, 3'b000, 3'b001, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 3'b100, 3'b001, 3'b100, 3'b001, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b001, 3'b100, 3'b001, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b100, 3'b001, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b001, 3'b010, 3'b101, 3'b010, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b101, 3'b010, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b001, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b001, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b001, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b001, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b001, 3'b100, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b001, 3'b100, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b001, 3'b010, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b001, 3'b010, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'b001, 3'b001, 3'b000, 3'b001, 0, 0, 1, 0, 0, 0));
        // Same-floor call during the door dwell restarts it without latching.
        vecs.push_back(v(1, 3'b000, 3'b010, 3'b000, 3'b001, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 3'b010, 3'b010, 3'b010, 3'b010, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b010, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b010, 3'b000, 3'b010, 0, 0, 0, 1, 1, 0));
        // Reset in the middle of a downward run.
        vecs.push_back(v(1, 3'b000, 3'b001, 3'b000, 3'b001, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 3'b001, 3'b100, 3'b001, 3'b100, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b100, 3'b001, 3'b100, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b001, 3'b100, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 0, 1, 1, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].call, vecs[i].sens);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
            chk($sformatf("interlock%0d", i),
                {11'd0, (motor_up & motor_down) | (door_open & (motor_up | motor_down))}, 12'd0);
        end

        // Multi-hot sensor while moving: sticky fault, pending still latches.
        step(1, 3'b000, 3'b001);
        step(0, 3'b100, 3'b001);
        step(0, 3'b000, 3'b001);
        chk("mh_moving", {11'd0, motor_up}, 12'd1);
        step(0, 3'b000, 3'b011);
        chk("mh_fault", outs(), {3'b100, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        step(0, 3'b010, 3'b001);
        step(0, 3'b000, 3'b001);
        step(0, 3'b000, 3'b010);
        chk("mh_sticky", outs(), {3'b110, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        step(1, 3'b000, 3'b001);
        chk("mh_reset", outs(), RST_OUT);

        // Stall between floors: fault after 16 cycles in motion with no new floor.
        step(0, 3'b000, 3'b000);
        step(0, 3'b100, 3'b000);
        step(0, 3'b000, 3'b000);
        chk("to_start", {11'd0, motor_up}, 12'd1);
        for (int n = 0; n < 15; n++) step(0, 3'b000, 3'b000);
        chk("to_before", {10'd0, motor_up, fault}, 12'b10);
        step(0, 3'b000, 3'b000);
        chk("to_fault", {10'd0, motor_up, fault}, 12'b01);
        step(1, 3'b000, 3'b001);
        chk("to_reset", outs(), RST_OUT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
